// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and empty_fifos bus encoding for the FIFO bank and its state machine
package fifo_pkg;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_PTR_W  = 3;
  localparam int FIFO_DATA_W = 6;
  localparam int UMBRAL_W    = 3;
  localparam int N_FIFOS     = 8;
  // Bit i carries the empty flag of bank instance i.
  typedef logic [N_FIFOS-1:0] empty_fifos_t;
  function automatic empty_fifos_t set_empty(input empty_fifos_t bus,
                                             input logic [$clog2(N_FIFOS)-1:0] idx,
                                             input logic e);
    empty_fifos_t b;
    b      = bus;
    b[idx] = e;
    return b;
  endfunction
endpackage

// File: rtl/fifo_umbrales_memoria_dp.sv
// memoria_dp: DEPTH x DATA_W register array, synchronous write, combinational read address
module memoria_dp #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 6,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  // Storage is left unreset; contents are meaningless until written.
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_umbrales.sv
// fifo_umbrales: synchronous FIFO with live low/high occupancy thresholds and sticky error
module fifo_umbrales
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int PTR_W  = FIFO_PTR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [UMBRAL_W-1:0] umbral_bajo,
  input  logic [UMBRAL_W-1:0] umbral_alto,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid_out,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic [PTR_W:0]      count,
  output logic                error
);
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid, r_error;
  logic              w_wr_en, w_rd_en, w_ovf, w_unf;
  logic [DATA_W-1:0] w_rd_data;
  // A pop frees the slot at full, so push is still accepted; there is no empty bypass.
  assign w_wr_en = push && (!full || pop);
  assign w_rd_en = pop && !empty;
  assign w_ovf   = push && full && !pop;
  assign w_unf   = pop && empty;
  memoria_dp #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );
  // Pointers, occupancy, registered read data and sticky error.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr_en && !w_rd_en) r_count <= r_count + (PTR_W+1)'(1);
      else if (w_rd_en && !w_wr_en) r_count <= r_count - (PTR_W+1)'(1);
      if (w_rd_en) r_data_out <= w_rd_data;
      r_valid <= w_rd_en;
      r_error <= r_error || w_ovf || w_unf;
    end
  assign count        = r_count;
  assign data_out     = r_data_out;
  assign valid_out    = r_valid;
  assign error        = r_error;
  assign empty        = r_count == '0;
  assign full         = r_count == (PTR_W+1)'(DEPTH);
  assign almost_empty = r_count <= (PTR_W+1)'(umbral_bajo);
  assign almost_full  = r_count >= (PTR_W+1)'(DEPTH) - (PTR_W+1)'(umbral_alto);
endmodule
